// File: rtl/tilt_led_mapper.sv
// Turns the I2C read-data byte stream into windowed signed axis averages and a
// flicker-filtered one-hot position on the 9-LED level bar.
//
//   state  | meaning
//   PH_LSB | next valid byte is the low byte of a sample
//   PH_MSB | next valid byte is the high byte; completes a sample
module tilt_led_mapper #(
    parameter int AVG_LOG2 = 2,
    parameter int SHIFT    = 8,
    parameter int HOLD     = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic        frame_start_i,
    output logic [15:0] sample_o,
    output logic        sample_valid_o,
    output logic [8:0]  led_o,
    output logic        led_valid_o
);

    localparam int         AW     = 16 + AVG_LOG2;
    localparam logic [3:0] HOLD_C = 4'(HOLD);

    typedef enum logic {PH_LSB, PH_MSB} phase_t;

    phase_t               phase_q, phase_d;
    logic [7:0]           low_q, low_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [AVG_LOG2-1:0]  cnt_q, cnt_d;
    logic signed [15:0]   sample_q, sample_d;
    logic                 svalid_q, svalid_d;
    logic [3:0]           cur_q, cur_d;
    logic [3:0]           cand_q, cand_d;
    logic [3:0]           hold_q, hold_d;
    logic [8:0]           led_q, led_d;
    logic                 lvalid_q, lvalid_d;

    logic                 sample_done;
    logic signed [15:0]   new_sample;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] avg_full;
    logic signed [15:0]   q_val;
    logic signed [17:0]   idx_wide;
    logic [3:0]           idx;
    logic [3:0]           hold_next;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q  <= PH_LSB;
            low_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            svalid_q <= 1'b0;
            cur_q    <= 4'd4;
            cand_q   <= 4'd4;
            hold_q   <= '0;
            led_q    <= 9'h010;
            lvalid_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            low_q    <= low_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            svalid_q <= svalid_d;
            cur_q    <= cur_d;
            cand_q   <= cand_d;
            hold_q   <= hold_d;
            led_q    <= led_d;
            lvalid_q <= lvalid_d;
        end
    end

    // Byte pairing and window accumulation
    always_comb begin
        phase_d     = phase_q;
        low_d       = low_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        svalid_d    = 1'b0;
        sample_done = byte_valid_i && !frame_start_i && (phase_q == PH_MSB);
        new_sample  = {byte_i, low_q};
        acc_sum     = acc_q + {{AVG_LOG2{new_sample[15]}}, new_sample};
        avg_full    = acc_sum >>> AVG_LOG2;

        if (frame_start_i) begin
            phase_d = PH_LSB;
            if (byte_valid_i) begin
                low_d   = byte_i;
                phase_d = PH_MSB;
            end
        end else if (byte_valid_i) begin
            if (phase_q == PH_LSB) begin
                low_d   = byte_i;
                phase_d = PH_MSB;
            end else begin
                phase_d = PH_LSB;
            end
        end

        if (sample_done) begin
            if (&cnt_q) begin
                sample_d = avg_full[15:0];
                svalid_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Bin mapping and consecutive-agreement hold filter
    always_comb begin
        cur_d     = cur_q;
        cand_d    = cand_q;
        hold_d    = hold_q;
        led_d     = led_q;
        lvalid_d  = 1'b0;
        q_val     = sample_q >>> SHIFT;
        idx_wide  = 18'sd4 + {{2{q_val[15]}}, q_val};
        hold_next = hold_q + 4'd1;

        if (idx_wide < 18'sd0)
            idx = 4'd0;
        else if (idx_wide > 18'sd8)
            idx = 4'd8;
        else
            idx = idx_wide[3:0];

        if (svalid_q) begin
            if (idx == cur_q) begin
                hold_d = '0;
            end else begin
                if (idx != cand_q) begin
                    cand_d    = idx;
                    hold_next = 4'd1;
                end
                if (hold_next == HOLD_C) begin
                    led_d    = 9'b1 << idx;
                    cur_d    = idx;
                    lvalid_d = 1'b1;
                    hold_d   = '0;
                end else begin
                    hold_d = hold_next;
                end
            end
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = svalid_q;
    assign led_o          = led_q;
    assign led_valid_o    = lvalid_q;

endmodule

// File: doc/tilt_led_mapper.md
Name: tilt_led_mapper

Overview:
- Downstream consumer of the I2C master's read-data stream (data byte + valid strobe).
- Pairs incoming bytes into signed 16-bit accelerometer axis samples (LSB first) and averages 2^AVG_LOG2 samples.
- Maps the average to a one-hot position on the 9-LED level bar, with a consecutive-agreement hold filter to suppress flicker.
- Sits between the I2C interface data outputs and the board LED pins.

Parameters:
- AVG_LOG2, 2: log2 of samples per averaging window (window = 4).
- SHIFT, 8: arithmetic right shift applied to the average to get the signed bin offset (bin width = 2^SHIFT LSB).
- HOLD, 1: consecutive averages that must agree on a new LED index before led_o changes. Legal range 1..15.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- byte_valid_i  input  1  one-cycle strobe; byte_i is valid.
- byte_i  input  8  read-data byte from the I2C master.
- frame_start_i  input  1  one-cycle pulse; realigns byte pairing so the next byte is an LSB.
- sample_o  output  16  latest window average, signed.
- sample_valid_o  output  1  one-cycle pulse when sample_o updates.
- led_o  output  9  one-hot LED bar; bit 4 = level.
- led_valid_o  output  1  one-cycle pulse when led_o changes.

Behaviour:
- Reset: all state is synchronous and active-high. On reset_i=1:
  - sample_o=0, sample_valid_o=0, led_o=9'h010, led_valid_o=0.
  - Byte phase=LSB, accumulator=0, window count=0, candidate index=4, hold count=0.
  - Reset asserted mid-window discards any partial sample and partial window.
- Byte assembly (phase FSM, states LSB and MSB):
  - LSB + byte_valid_i: latch the byte as the low byte, go to MSB.
  - MSB + byte_valid_i: form {byte_i, low byte} as a signed sample, go to LSB.
  - frame_start_i forces LSB. If frame_start_i and byte_valid_i occur in the same cycle, the byte is taken as an LSB.
  - A half-received sample discarded by frame_start_i does not enter the accumulator.
- Averaging:
  - Accumulator is signed, width 16+AVG_LOG2; it cannot overflow.
  - On each completed sample, in the MSB-byte cycle t: acc += sample and the count increments.
  - On the sample that completes the window:
    - sample_o = (acc + sample) >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
    - sample_valid_o pulses at t+1.
    - Accumulator and count clear, so the next sample starts a new window.
  - Windows are back-to-back with no skipped samples. Count wraps from 2^AVG_LOG2-1 to 0.
- Index mapping, evaluated in the cycle sample_valid_o=1:
  - q = sample_o >>> SHIFT (signed).
  - idx = 4 + q, clamped to [0,8].
- Hold filter:
  - idx == current LED index: hold count cleared.
  - idx != current and idx != candidate: candidate=idx, hold count=1.
  - idx != current and idx == candidate: hold count increments.
  - When hold count reaches HOLD: led_o = 1<<idx, led_valid_o pulses, hold count clears.
  - With HOLD=1 every differing idx updates immediately.
- Latency: final MSB byte at t -> sample_valid_o at t+1 -> led_o/led_valid_o at t+2.
- Throughput and bounds:
  - Accepts one byte per cycle indefinitely; no backpressure.
  - Bytes arriving while the mapping stage is busy are still accepted; the stages are independent pipeline registers.
  - led_o is always exactly one-hot; no index outside 0..8 can occur.

Test Plan:
- Reset and idle: assert reset_i 2 cycles with byte_valid_i toggling -> led_o=9'h010, both valid outputs 0; after release with no input, outputs stay unchanged.
- Basic path (defaults): four samples 0x0100 (bytes 00,01 ×4, back-to-back) -> sample_o=0x0100 with pulse 1 cycle after last MSB; led_o=9'h020 with led_valid_o pulse 2 cycles after last MSB.
- Clamping:
  - Four samples 0x8000 -> sample_o=0x8000, led_o=9'h001.
  - Then four samples 0x7FFF -> led_o=9'h100.
  - Then four samples 0x0000 -> led_o=9'h010.
- Arithmetic rounding: samples 0xFFFF,0,0,0 -> sample_o=0xFFFF (-1), q=-1, led_o=9'h008; samples 0x00FF ×4 -> led_o returns to 9'h010.
- Hold filter (HOLD=3), windows mapping to idx 5,5,6,6,6 -> no change after 5,5 (candidate restarts on 6); led_o=9'h040 only after the third consecutive 6, single led_valid_o pulse.
- Alignment and reset:
  - Send LSB 0x00, then frame_start_i with byte 0x00, then 0x01 -> sample recorded as 0x0100, first byte discarded.
  - Assert reset_i after 2 of 4 samples, then send 4 samples of 0x0100 -> sample_o=0x0100, with no contribution from the pre-reset samples.
